// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder: FSM state type,
// nibble width and the counter-width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIB_BITS = 4;

    // Width of a counter that must index nib nibbles, never narrower than 1.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead slice. Produces the nibble sum with
// carry-in ci, the group generate/propagate terms and the carry into bit 3
// (the carry into the operand MSB when this is the top nibble).
module cla_nibble_slice
    import cla_pkg::*;
(
    input  logic [NIB_BITS-1:0] a,
    input  logic [NIB_BITS-1:0] b,
    input  logic                ci,
    output logic [NIB_BITS-1:0] s,
    output logic                gen,
    output logic                prop,
    output logic                c3
);

    logic [NIB_BITS-1:0] g;
    logic [NIB_BITS-1:0] p;
    logic [NIB_BITS-1:0] c;

    // Lookahead carries for every bit position plus the group terms.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
        gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        prop = &p;
        c3   = c[3];
    end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle W-bit adder that resolves one nibble per clock through a single
// shared carry-lookahead slice, with valid/ready handshakes on both sides.
// Optional macro CLA_OVERFLOW_EN adds a registered signed-overflow output ovf.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int W   = 32,
    parameter int NIB = W / NIB_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
`ifdef CLA_OVERFLOW_EN
    output logic         ovf,
`endif
    output logic         cout
);

    localparam int            CW   = cnt_width(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t state;
    state_t next_state;

    logic [NIB-1:0][NIB_BITS-1:0] a_q;
    logic [NIB-1:0][NIB_BITS-1:0] b_q;
    logic [NIB-1:0][NIB_BITS-1:0] s_q;
    logic [CW-1:0]                cnt;
    logic                         carry_q;

    logic                accept;
    logic                finish;
    logic                out_take;
    logic [NIB_BITS-1:0] sl_s;
    logic                sl_gen;
    logic                sl_prop;
    logic                sl_c3;
    logic                carry_next;

    assign s          = s_q;
    assign carry_next = sl_gen | (sl_prop & carry_q);

    cla_nibble_slice u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .ci   (carry_q),
        .s    (sl_s),
        .gen  (sl_gen),
        .prop (sl_prop),
        .c3   (sl_c3)
    );

    // State register; in_ready is registered so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == IDLE);
        end
    end

    // Next-state logic and the per-state control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        out_take   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    out_take   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, one nibble of sum per RUN cycle and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                cnt     <= '0;
            end
            if (state == RUN) begin
                s_q[cnt] <= sl_s;
                carry_q  <= carry_next;
                cnt      <= cnt + 1'b1;
            end
            if (finish) begin
                cout      <= carry_next;
                out_valid <= 1'b1;
            end
            if (out_take) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CLA_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (finish) begin
            ovf <= sl_c3 ^ carry_next;
        end
    end
`else
    logic unused_c3;
    assign unused_c3 = sl_c3;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard testbench for cla_serial_adder: the driver pushes the expected
// result of each accepted request, and an independent monitor pops and checks
// whenever a result is handed over.
module tb_cla_serial_adder;

    localparam int W   = 32;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef CLA_OVERFLOW_EN
    logic         ovf;
`endif

    logic readyMode;
    logic readyRand;
    logic readyForce;

    exp_t expQ[$];
    int   latQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    cla_serial_adder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef CLA_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    assign out_ready = readyMode ? readyRand : readyForce;

    // Random consumer backpressure, changed just after each rising edge.
    initial begin
        readyRand = 1'b1;
        forever begin
            @(posedge clk);
            #1 readyRand = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: plain wide arithmetic plus the sign rule for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t        e;
        logic [W:0]  sum;
        sum    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.s    = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (sum[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int gap);
        bit accepted;
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                expQ.push_back(model(av, bv, cv));
                latQ.push_back(cycle + 1 + NIB);
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 1000 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", expQ.size());
        end
        @(negedge clk);
    endtask

    // Monitor: latency on each rising out_valid, stability while held,
    // and result comparison on every output handshake.
    initial begin
        logic         prevValid;
        logic [W-1:0] heldS;
        logic         heldCout;
        exp_t         e;
        int           lat;
        prevValid = 1'b0;
        heldS     = '0;
        heldCout  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevValid = 1'b0;
            end else begin
                if (out_valid && !prevValid) begin
                    if (latQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_valid: got out_valid=1, expected 0");
                    end else begin
                        lat = latQ.pop_front();
                        checkOutput("latency_cycle", 64'(cycle), 64'(lat));
                    end
                    heldS    = s;
                    heldCout = cout;
                end else if (out_valid) begin
                    checkOutput("hold_s", 64'(s), 64'(heldS));
                    checkOutput("hold_cout", 64'(cout), 64'(heldCout));
                end
                if (out_valid && out_ready && expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("sum", 64'(s), 64'(e.s));
                    checkOutput("cout", 64'(cout), 64'(e.cout));
`ifdef CLA_OVERFLOW_EN
                    checkOutput("ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
                prevValid = out_valid;
            end
        end
    end

    initial begin
        bit seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        readyMode  = 1'b0;
        readyForce = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_s", 64'(s), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef CLA_OVERFLOW_EN
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        #1 checkOutput("release_in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        // Basic add and full ripple.
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        waitDrain();
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        waitDrain();

        // Backpressure: result held in DONE with out_ready low.
        readyForce = 1'b0;
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput("bp_valid_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_s", 64'(s), 64'h2345_6789);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1 readyForce = 1'b1;
        @(posedge clk);
        #1 readyForce = 1'b0;
        @(negedge clk);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        readyForce = 1'b1;

        // Reset during RUN discards the partial result.
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        expQ.delete();
        latQ.delete();
        #1;
        checkOutput("midrun_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrun_s", 64'(s), 64'd0);
        checkOutput("midrun_cout", 64'(cout), 64'd0);
        checkOutput("midrun_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrun_release_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        waitDrain();

        // Random traffic with random request gaps and consumer backpressure.
        readyMode = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 50 == 0) ra = '1;
            if (n % 70 == 0) rb = '1;
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
